// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: groups the fetch requester, data requester and shared
// memory channel signals of the memory bus arbiter.
// master modport: the arbiter's view. slave modport: the requesters and the memory.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // fetch requester
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_done;

  // data requester
  logic              d_re;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;

  // shared memory channel
  logic              m_valid;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [BE_W-1:0]   m_be;
  logic              m_ready;
  logic [DATA_W-1:0] m_rdata;

  // control unit feedback
  logic              stall;
  logic              bus_error;

  modport master (
    input  i_req, i_addr,
    output i_rdata, i_done,
    input  d_re, d_we, d_addr, d_wdata, d_be,
    output d_rdata, d_done,
    output m_valid, m_we, m_addr, m_wdata, m_be,
    input  m_ready, m_rdata,
    output stall, bus_error
  );

  modport slave (
    output i_req, i_addr,
    input  i_rdata, i_done,
    output d_re, d_we, d_addr, d_wdata, d_be,
    input  d_rdata, d_done,
    input  m_valid, m_we, m_addr, m_wdata, m_be,
    output m_ready, m_rdata,
    input  stall, bus_error
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: serialises instruction fetch and load/store accesses onto a
// single valid/ready memory channel, data having fixed priority over fetch.
// Optional feature: define MEM_ARB_TIMEOUT_EN to enable the wait-state
// watchdog that aborts a stuck access and raises the sticky bus_error flag.
module mem_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_arbiter_if.master bus
);
  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic              r_we;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_i_done;
  logic              r_d_done;

  logic              w_i_req;
  logic              w_d_req;
  logic              w_idle;
  logic              w_m_valid;
  logic              w_complete;
  logic              w_abort;
  logic              w_finish;
  logic              w_grant_d;
  logic              w_grant_i;
  logic              w_bus_error;

  // A requester whose done pulse is high this cycle is about to drop its
  // request, so it is masked to avoid granting it a second time.
  assign w_d_req    = (bus.d_re | bus.d_we) & ~r_d_done;
  assign w_i_req    = bus.i_req & ~r_i_done;
  assign w_idle     = (r_state == IDLE);
  // Valid is a pure decode of the state register, so an asynchronous reset
  // drops it immediately.
  assign w_m_valid  = ~w_idle;
  assign w_complete = w_m_valid & bus.m_ready;
  assign w_finish   = w_complete | w_abort;
  assign w_grant_d  = w_idle & w_d_req;
  assign w_grant_i  = w_idle & ~w_d_req & w_i_req;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_bus_error;

  // The abort fires on the edge at which the wait counter reaches the limit.
  assign w_abort     = w_m_valid & ~bus.m_ready &
                       (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_bus_error = r_bus_error;

  // Count wait states of the current grant; latch a sticky error on abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt  <= '0;
      r_bus_error <= 1'b0;
    end else begin
      if (w_grant_d | w_grant_i) begin
        r_wait_cnt <= '0;
      end else if (w_m_valid & ~bus.m_ready) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_abort) begin
        r_bus_error <= 1'b1;
      end
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign w_abort     = 1'b0;
  assign w_bus_error = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode: data wins over fetch, a granted access holds until it finishes.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_d_req) begin
          w_state_next = GRANT_D;
        end else if (w_i_req) begin
          w_state_next = GRANT_I;
        end
      end
      GRANT_I, GRANT_D: begin
        if (w_finish) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Latch the request payload on the grant edge; it is held for the whole access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_we    <= 1'b0;
    end else if (w_grant_d) begin
      r_addr  <= bus.d_addr;
      r_wdata <= bus.d_wdata;
      r_be    <= bus.d_be;
      r_we    <= bus.d_we;
    end else if (w_grant_i) begin
      r_addr  <= bus.i_addr;
      r_wdata <= '0;
      r_be    <= '1;
      r_we    <= 1'b0;
    end
  end

  // Capture read data for the granted requester and pulse its done flag.
  // An aborted read returns zero; writes never touch the read-data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_done  <= 1'b0;
      r_d_done  <= 1'b0;
    end else begin
      r_i_done <= (r_state == GRANT_I) & w_finish;
      r_d_done <= (r_state == GRANT_D) & w_finish;
      if (w_finish & ~r_we) begin
        if (r_state == GRANT_I) begin
          r_i_rdata <= w_complete ? bus.m_rdata : '0;
        end else if (r_state == GRANT_D) begin
          r_d_rdata <= w_complete ? bus.m_rdata : '0;
        end
      end
    end
  end

  assign bus.m_valid   = w_m_valid;
  assign bus.m_we      = r_we;
  assign bus.m_addr    = r_addr;
  assign bus.m_wdata   = r_wdata;
  assign bus.m_be      = r_be;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.i_done    = r_i_done;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_done    = r_d_done;
  assign bus.bus_error = w_bus_error;
  assign bus.stall     = (w_idle & (w_d_req | w_i_req)) | ~w_idle;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed test of mem_bus_arbiter. Inputs change 2 time
// units after each rising edge; outputs are checked a few units later.
// Cycle numbering follows the request: cycle 0 is the cycle the request is first seen.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_bus_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.i_req    = 1'b0;
    bus.i_addr   = '0;
    bus.d_re     = 1'b0;
    bus.d_we     = 1'b0;
    bus.d_addr   = '0;
    bus.d_wdata  = '0;
    bus.d_be     = '0;
    bus.m_ready  = 1'b0;
    bus.m_rdata  = '0;
    #3;
    chk("rst_m_valid", 32'(bus.m_valid), 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_m_be", 32'(bus.m_be), 0);
    chk("rst_i_done", 32'(bus.i_done), 0);
    chk("rst_d_done", 32'(bus.d_done), 0);
    chk("rst_stall", 32'(bus.stall), 0);
    chk("rst_bus_error", 32'(bus.bus_error), 0);
    cyc();
    rst = 1'b0;
    cyc();

    // single fetch, zero wait states
    bus.i_req = 1'b1; bus.i_addr = 32'h100; bus.m_ready = 1'b1; bus.m_rdata = 32'h00500093;
    #1;
    chk("f_c0_stall", 32'(bus.stall), 1);
    chk("f_c0_m_valid", 32'(bus.m_valid), 0);
    cyc();
    chk("f_c1_m_valid", 32'(bus.m_valid), 1);
    chk("f_c1_m_we", 32'(bus.m_we), 0);
    chk("f_c1_m_addr", bus.m_addr, 32'h100);
    chk("f_c1_m_be", 32'(bus.m_be), 32'hf);
    chk("f_c1_stall", 32'(bus.stall), 1);
    chk("f_c1_i_done", 32'(bus.i_done), 0);
    cyc();
    chk("f_c2_i_done", 32'(bus.i_done), 1);
    chk("f_c2_i_rdata", bus.i_rdata, 32'h00500093);
    chk("f_c2_m_valid", 32'(bus.m_valid), 0);
    chk("f_c2_stall", 32'(bus.stall), 0);
    bus.i_req = 1'b0;
    cyc();
    chk("f_c3_i_done", 32'(bus.i_done), 0);
    chk("f_c3_m_valid", 32'(bus.m_valid), 0);

    // store with three wait states
    bus.d_we = 1'b1; bus.d_addr = 32'h2004; bus.d_wdata = 32'hDEADBEEF; bus.d_be = 4'b0011;
    bus.m_ready = 1'b0; bus.m_rdata = 32'hCAFEF00D;
    #1;
    chk("st_c0_stall", 32'(bus.stall), 1);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      if (k == 4) bus.m_ready = 1'b1;
      #1;
      chk($sformatf("st_c%0d_m_valid", k), 32'(bus.m_valid), 1);
      chk($sformatf("st_c%0d_m_we", k), 32'(bus.m_we), 1);
      chk($sformatf("st_c%0d_m_addr", k), bus.m_addr, 32'h2004);
      chk($sformatf("st_c%0d_m_wdata", k), bus.m_wdata, 32'hDEADBEEF);
      chk($sformatf("st_c%0d_m_be", k), 32'(bus.m_be), 32'h3);
      chk($sformatf("st_c%0d_d_done", k), 32'(bus.d_done), 0);
    end
    cyc();
    chk("st_c5_d_done", 32'(bus.d_done), 1);
    chk("st_c5_d_rdata", bus.d_rdata, 32'h0);
    chk("st_c5_m_valid", 32'(bus.m_valid), 0);
    bus.d_we = 1'b0;
    cyc();
    chk("st_c6_d_done", 32'(bus.d_done), 0);

    // simultaneous fetch and load: data first
    bus.i_req = 1'b1; bus.i_addr = 32'h200; bus.d_re = 1'b1; bus.d_addr = 32'h3000;
    bus.m_ready = 1'b1; bus.m_rdata = 32'h11111111;
    #1;
    chk("pr_c0_stall", 32'(bus.stall), 1);
    cyc();
    chk("pr_c1_m_valid", 32'(bus.m_valid), 1);
    chk("pr_c1_m_addr", bus.m_addr, 32'h3000);
    chk("pr_c1_m_we", 32'(bus.m_we), 0);
    chk("pr_c1_stall", 32'(bus.stall), 1);
    cyc();
    chk("pr_c2_d_done", 32'(bus.d_done), 1);
    chk("pr_c2_d_rdata", bus.d_rdata, 32'h11111111);
    chk("pr_c2_i_rdata", bus.i_rdata, 32'h00500093);
    chk("pr_c2_i_done", 32'(bus.i_done), 0);
    bus.d_re = 1'b0; bus.m_rdata = 32'h22222222;
    #1;
    chk("pr_c2_stall", 32'(bus.stall), 1);
    cyc();
    chk("pr_c3_m_valid", 32'(bus.m_valid), 1);
    chk("pr_c3_m_addr", bus.m_addr, 32'h200);
    chk("pr_c3_m_be", 32'(bus.m_be), 32'hf);
    chk("pr_c3_stall", 32'(bus.stall), 1);
    cyc();
    chk("pr_c4_i_done", 32'(bus.i_done), 1);
    chk("pr_c4_i_rdata", bus.i_rdata, 32'h22222222);
    chk("pr_c4_d_rdata", bus.d_rdata, 32'h11111111);
    chk("pr_c4_stall", 32'(bus.stall), 0);
    bus.i_req = 1'b0;
    cyc();

    // read and write together: write wins, load data untouched
    bus.d_re = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h44; bus.d_wdata = 32'h12345678;
    bus.d_be = 4'hf; bus.m_rdata = 32'h33333333;
    cyc();
    chk("rw_c1_m_we", 32'(bus.m_we), 1);
    chk("rw_c1_m_wdata", bus.m_wdata, 32'h12345678);
    cyc();
    chk("rw_c2_d_done", 32'(bus.d_done), 1);
    chk("rw_c2_d_rdata", bus.d_rdata, 32'h11111111);
    bus.d_re = 1'b0; bus.d_we = 1'b0;
    cyc();

    // reset in the middle of a pending read
    bus.d_re = 1'b1; bus.d_addr = 32'h5000; bus.m_ready = 1'b0;
    cyc();
    chk("rr_c1_m_valid", 32'(bus.m_valid), 1);
    cyc();
    rst = 1'b1; bus.d_re = 1'b0;
    #1;
    chk("rr_m_valid", 32'(bus.m_valid), 0);
    chk("rr_stall", 32'(bus.stall), 0);
    chk("rr_m_addr", bus.m_addr, 0);
    chk("rr_m_we", 32'(bus.m_we), 0);
    chk("rr_m_wdata", bus.m_wdata, 0);
    chk("rr_m_be", 32'(bus.m_be), 0);
    chk("rr_d_rdata", bus.d_rdata, 0);
    chk("rr_i_rdata", bus.i_rdata, 0);
    chk("rr_d_done", 32'(bus.d_done), 0);
    chk("rr_i_done", 32'(bus.i_done), 0);
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("rr_post%0d_d_done", k), 32'(bus.d_done), 0);
      chk($sformatf("rr_post%0d_m_valid", k), 32'(bus.m_valid), 0);
    end

    // preload d_rdata with a non-zero value
    bus.d_re = 1'b1; bus.d_addr = 32'h60; bus.m_ready = 1'b1; bus.m_rdata = 32'h44444444;
    cyc();
    cyc();
    chk("pl_d_done", 32'(bus.d_done), 1);
    chk("pl_d_rdata", bus.d_rdata, 32'h44444444);
    bus.d_re = 1'b0;
    cyc();

    // load against a memory that never becomes ready
    bus.d_re = 1'b1; bus.d_addr = 32'h64; bus.m_ready = 1'b0; bus.m_rdata = 32'hFFFFFFFF;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk($sformatf("to_c%0d_m_valid", k), 32'(bus.m_valid), 1);
      chk($sformatf("to_c%0d_d_done", k), 32'(bus.d_done), 0);
      chk($sformatf("to_c%0d_bus_error", k), 32'(bus.bus_error), 0);
    end
    cyc();
    chk("to_c5_d_done", 32'(bus.d_done), 1);
    chk("to_c5_d_rdata", bus.d_rdata, 32'h0);
    chk("to_c5_bus_error", 32'(bus.bus_error), 1);
    chk("to_c5_m_valid", 32'(bus.m_valid), 0);
    bus.d_re = 1'b0;
    cyc();
    bus.i_req = 1'b1; bus.i_addr = 32'h300; bus.m_ready = 1'b1; bus.m_rdata = 32'h55555555;
    cyc();
    cyc();
    chk("to_f_i_done", 32'(bus.i_done), 1);
    chk("to_f_i_rdata", bus.i_rdata, 32'h55555555);
    chk("to_f_bus_error", 32'(bus.bus_error), 1);
    bus.i_req = 1'b0;
    cyc();
    chk("to_end_bus_error", 32'(bus.bus_error), 1);
`else
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk($sformatf("nw_c%0d_m_valid", k), 32'(bus.m_valid), 1);
      chk($sformatf("nw_c%0d_d_done", k), 32'(bus.d_done), 0);
      chk($sformatf("nw_c%0d_bus_error", k), 32'(bus.bus_error), 0);
      if (k == 6) bus.m_ready = 1'b1;
    end
    cyc();
    chk("nw_c7_d_done", 32'(bus.d_done), 1);
    chk("nw_c7_d_rdata", bus.d_rdata, 32'hFFFFFFFF);
    chk("nw_c7_bus_error", 32'(bus.bus_error), 0);
    bus.d_re = 1'b0;
    cyc();
    chk("nw_c8_d_done", 32'(bus.d_done), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the core's single memory port between instruction fetch and the data bus. Fetch requests come from the fetch stage (address-out / IR-load phases); data requests come from load/store execution. The block serialises them onto one valid/ready memory channel and drives `stall` back to the control unit, which freezes its phase sequencer until the access it needs has completed.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (byte enables are `DATA_W/8` bits wide)
- `TIMEOUT_CYCLES`, 255, watchdog limit (only used with the macro)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `i_req`  in  1  fetch request, held until `i_done`
- `i_addr`  in  ADDR_W  fetch address
- `i_rdata`  out  DATA_W  fetched word, registered
- `i_done`  out  1  one-cycle completion pulse for fetch
- `d_re` / `d_we`  in  1 each  data read / write request, held until `d_done`
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_be`  in  DATA_W/8  store byte enables
- `d_rdata`  out  DATA_W  load data, registered
- `d_done`  out  1  one-cycle completion pulse for data
- `m_valid`, `m_we`  out  1 each  memory request valid / write
- `m_addr`, `m_wdata`, `m_be`  out  request payload
- `m_ready`  in  1  memory accepts and completes the request this cycle
- `m_rdata`  in  DATA_W  read data, valid when `m_valid & m_ready & ~m_we`
- `stall`  out  1  control unit must hold its state
- `bus_error`  out  1  sticky timeout flag

## Operation
- States:
  - IDLE
  - GRANT_I
  - GRANT_D
- Masking: a requester whose `*_done` is high this cycle is ignored in IDLE; it must drop its request that cycle.
- IDLE to GRANT_D: unmasked `d_re|d_we`. Data has fixed priority over fetch.
- IDLE to GRANT_I: unmasked `i_req` with no data request.
- On the grant edge, the payload is latched into internal registers and `m_valid` rises.
  - Fetch: `m_we=0`, `m_be` all ones.
  - Data: `m_we=d_we`.
- `d_re` and `d_we` both high: write wins and `d_rdata` is left unchanged.
- Payload registers are stable while `m_valid=1`. Requester inputs are not observed while granted.
- Completion occurs on a cycle with `m_valid & m_ready`. At that edge:
  - The read data is captured into `i_rdata` or `d_rdata`; the other output is unchanged.
  - The matching `*_done` is set for exactly one cycle.
  - `m_valid` drops and the state returns to IDLE.
- `stall` = (any unmasked request in IDLE) OR (state != IDLE). It is combinational from registered state and request inputs.
- Reset values: state IDLE, and every output 0 (`m_*`, `*_rdata`, `*_done`, `bus_error`). `stall` follows its equation.
- Reset mid-transfer: the transfer is abandoned immediately (`m_valid` low asynchronously) and no `done` is issued.

## Timing
- Minimum latency, request to done: 2 cycles.
  - Request seen in IDLE at cycle 0.
  - `m_valid` high in cycle 1; with `m_ready=1` in cycle 1, `*_done` is high in cycle 2.
- Each wait cycle (`m_ready=0`) adds one cycle.
- A new grant may occur in the same cycle as a `done` pulse (IDLE, with the finished requester masked). Back-to-back throughput is one access per 2 cycles.
- Simultaneous `i_req` and a data request in IDLE: data is granted first. Fetch is granted in the cycle `d_done` is high, provided `i_req` is still set.
- Under continuous data requests fetch can be starved. The control unit's phase sequencing never issues both at once for more than one access.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A counter clears on grant and increments each cycle `m_valid & ~m_ready`.
  - When it reaches `TIMEOUT_CYCLES`, the access aborts: `m_valid` drops, state returns to IDLE, the granted `*_done` pulses, and the registered read data is forced to 0.
  - `bus_error` is set and stays set until reset.
- Not defined:
  - There is no counter; an access waits indefinitely for `m_ready`.
  - `bus_error` is tied to 0.

## Test plan
- Single fetch, `i_addr=0x100`, `m_ready` high immediately, `m_rdata=0x00500093`: `m_valid` high in cycle 1 only, `i_rdata=0x00500093` and `i_done` in cycle 2, `stall` low in cycle 2.
- Store, `d_we=1`, `d_addr=0x2004`, `d_wdata=0xDEADBEEF`, `d_be=4'b0011`, 3 wait states: payload stable for 4 cycles with `m_we=1`, `d_done` in cycle 5, `d_rdata` unchanged.
- `i_req` and `d_re` together at cycle 0: data granted first, `d_done` in cycle 2, fetch grant in cycle 2, `i_done` in cycle 4; `stall` high throughout cycles 0–3.
- Assert `rst` in cycle 2 of a pending read: `m_valid`, `stall` (with requests low) and all outputs are 0 immediately; no `done` after release.
- With `MEM_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES=4`, `m_ready` held low on a load: `d_done` pulses with `d_rdata=0` after 4 wait cycles, `bus_error` stays 1 through subsequent successful accesses.
- `d_re=d_we=1`: write issued (`m_we=1`) and `d_rdata` retains its previous value.
